// File: rtl/ysyx_22051468_lsu_if.sv
// Data-memory bus between the load/store unit and the data memory.
// A request is a valid/ready handshake; load data returns later on rvalid.
interface ysyx_22051468_lsu_if #(
   parameter int WIDTH = 64
);
   logic             mem_valid;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [7:0]       mem_wstrb;
   logic             mem_ready;
   logic             mem_rvalid;
   logic [WIDTH-1:0] mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/ysyx_22051468_lsu.sv
// Memory-access stage: takes one load/store from execute, runs it on the
// data bus, aligns store lanes/strobes, extends load data and writes back.
module ysyx_22051468_lsu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             is_load_i,
   input  logic             is_store_i,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [4:0]       rd_addr_i,
   ysyx_22051468_lsu_if.master bus,
   output logic [4:0]       w_addr_o,
   output logic [WIDTH-1:0] w_data_o,
   output logic             w_en_o,
   output logic             hold_pipeline_o,
   output logic             misalign_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t     state;
   logic [2:0] funct3_q;
   logic [2:0] off_q;
   logic [4:0] rd_q;

   logic             legal;
   logic             misaligned;
   logic             accept;
   logic [WIDTH-1:0] st_wdata;
   logic [7:0]       st_wstrb;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] ld_result;

   // Decode the incoming request: legality (one op, supported size) and alignment.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      if (req_valid && (is_load_i ^ is_store_i)) begin
         legal = is_load_i ? (funct3_i != 3'b111) : (funct3_i[2] == 1'b0);
      end
      case (funct3_i[1:0])
         2'b01:   misaligned = addr_i[0];
         2'b10:   misaligned = |addr_i[1:0];
         2'b11:   misaligned = |addr_i[2:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign accept          = (state == S_IDLE) && legal && !misaligned;
   assign req_ready       = (state == S_IDLE);
   assign hold_pipeline_o = accept || (state == S_REQ) || (state == S_WAIT);

   // Replicate store data across every lane of its size and place the strobes at the offset.
   always_comb begin
      st_wdata = wdata_i;
      st_wstrb = 8'hFF;
      case (funct3_i[1:0])
         2'b00: begin
            st_wdata = {8{wdata_i[7:0]}};
            st_wstrb = 8'h01 << addr_i[2:0];
         end
         2'b01: begin
            st_wdata = {4{wdata_i[15:0]}};
            st_wstrb = 8'h03 << addr_i[2:0];
         end
         2'b10: begin
            st_wdata = {2{wdata_i[31:0]}};
            st_wstrb = 8'h0F << addr_i[2:0];
         end
         default: begin
            st_wdata = wdata_i;
            st_wstrb = 8'hFF;
         end
      endcase
   end

   // Move the addressed bytes down to bit 0, then sign- or zero-extend by size.
   always_comb begin
      shifted   = bus.mem_rdata >> {off_q, 3'b000};
      ld_result = shifted;
      case (funct3_q)
         3'b000:  ld_result = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  ld_result = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b010:  ld_result = {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
         3'b100:  ld_result = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  ld_result = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         3'b110:  ld_result = {{(WIDTH-32){1'b0}}, shifted[31:0]};
         default: ld_result = shifted;
      endcase
   end

   // Transaction FSM with registered bus, write-back and misalign outputs.
   // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         funct3_q      <= 3'b000;
         off_q         <= 3'b000;
         rd_q          <= 5'd0;
         bus.mem_valid <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= 8'h00;
         w_en_o        <= 1'b0;
         w_addr_o      <= 5'd0;
         w_data_o      <= '0;
         misalign_o    <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (legal && misaligned) begin
                  misalign_o <= 1'b1;
               end else if (accept) begin
                  funct3_q      <= funct3_i;
                  off_q         <= addr_i[2:0];
                  rd_q          <= rd_addr_i;
                  bus.mem_valid <= 1'b1;
                  bus.mem_we    <= is_store_i;
                  bus.mem_addr  <= {addr_i[WIDTH-1:3], 3'b000};
                  bus.mem_wdata <= is_store_i ? st_wdata : '0;
                  bus.mem_wstrb <= is_store_i ? st_wstrb : 8'h00;
                  state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.mem_ready) begin
                  bus.mem_valid <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  state         <= bus.mem_we ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  if (rd_q != 5'd0) begin
                     w_en_o   <= 1'b1;
                     w_addr_o <= rd_q;
                     w_data_o <= ld_result;
                  end
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               w_en_o   <= 1'b0;
               w_addr_o <= 5'd0;
               w_data_o <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22051468_lsu.sv
// Directed bench for the load/store unit: a vector table run through a
// best-case bus, plus hand sequences for wait states, stalls and reset.
module tb_ysyx_22051468_lsu;

   typedef enum logic [1:0] {K_LOAD, K_STORE, K_MISAL, K_IGN} kind_t;

   typedef struct {
      string       name;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [4:0]  rd;
      logic [63:0] rdata;
      kind_t       kind;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wstrb;
      logic        exp_wen;
      logic [63:0] exp_res;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        is_load_i = 1'b0;
   logic        is_store_i = 1'b0;
   logic [2:0]  funct3_i = 3'b000;
   logic [63:0] addr_i = '0;
   logic [63:0] wdata_i = '0;
   logic [4:0]  rd_addr_i = 5'd0;
   logic [4:0]  w_addr_o;
   logic [63:0] w_data_o;
   logic        w_en_o;
   logic        hold_pipeline_o;
   logic        misalign_o;

   int n_vec = 0;
   int n_err = 0;

   ysyx_22051468_lsu_if #(.WIDTH(64)) bif ();

   ysyx_22051468_lsu #(.WIDTH(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .is_load_i       (is_load_i),
      .is_store_i      (is_store_i),
      .funct3_i        (funct3_i),
      .addr_i          (addr_i),
      .wdata_i         (wdata_i),
      .rd_addr_i       (rd_addr_i),
      .bus             (bif.master),
      .w_addr_o        (w_addr_o),
      .w_data_o        (w_data_o),
      .w_en_o          (w_en_o),
      .hold_pipeline_o (hold_pipeline_o),
      .misalign_o      (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input vec_t v);
      req_valid  = 1'b1;
      is_load_i  = v.ld;
      is_store_i = v.st;
      funct3_i   = v.f3;
      addr_i     = v.addr;
      wdata_i    = v.wdata;
      rd_addr_i  = v.rd;
   endtask

   task automatic clear_req();
      req_valid  = 1'b0;
      is_load_i  = 1'b0;
      is_store_i = 1'b0;
      funct3_i   = 3'b000;
      addr_i     = '0;
      wdata_i    = '0;
      rd_addr_i  = 5'd0;
   endtask

   // One request with a zero-wait bus: ready in the cycle after accept, rvalid right after.
   task automatic apply_vec(input vec_t v);
      logic acc;
      acc = (v.kind == K_LOAD) || (v.kind == K_STORE);
      drive_req(v);
      #1;
      check({v.name, ".T.ready"}, {63'd0, req_ready}, 64'd1);
      check({v.name, ".T.hold"}, {63'd0, hold_pipeline_o}, {63'd0, acc});
      step();
      clear_req();
      #1;
      if (!acc) begin
         check({v.name, ".T1.misalign"}, {63'd0, misalign_o}, {63'd0, v.kind == K_MISAL});
         check({v.name, ".T1.mem_valid"}, {63'd0, bif.mem_valid}, 64'd0);
         check({v.name, ".T1.hold"}, {63'd0, hold_pipeline_o}, 64'd0);
         check({v.name, ".T1.ready"}, {63'd0, req_ready}, 64'd1);
         step();
         check({v.name, ".T2.misalign"}, {63'd0, misalign_o}, 64'd0);
         check({v.name, ".T2.w_en"}, {63'd0, w_en_o}, 64'd0);
      end else begin
         check({v.name, ".T1.mem_valid"}, {63'd0, bif.mem_valid}, 64'd1);
         check({v.name, ".T1.mem_we"}, {63'd0, bif.mem_we}, {63'd0, v.kind == K_STORE});
         check({v.name, ".T1.mem_addr"}, bif.mem_addr, v.exp_addr);
         check({v.name, ".T1.hold"}, {63'd0, hold_pipeline_o}, 64'd1);
         if (v.kind == K_STORE) begin
            check({v.name, ".T1.wdata"}, bif.mem_wdata, v.exp_wdata);
            check({v.name, ".T1.wstrb"}, {56'd0, bif.mem_wstrb}, {56'd0, v.exp_wstrb});
         end
         bif.mem_ready = 1'b1;
         step();
         bif.mem_ready = 1'b0;
         #1;
         check({v.name, ".T2.mem_valid"}, {63'd0, bif.mem_valid}, 64'd0);
         if (v.kind == K_STORE) begin
            check({v.name, ".T2.hold"}, {63'd0, hold_pipeline_o}, 64'd0);
            check({v.name, ".T2.ready"}, {63'd0, req_ready}, 64'd1);
            check({v.name, ".T2.w_en"}, {63'd0, w_en_o}, 64'd0);
         end else begin
            check({v.name, ".T2.hold"}, {63'd0, hold_pipeline_o}, 64'd1);
            bif.mem_rvalid = 1'b1;
            bif.mem_rdata  = v.rdata;
            step();
            bif.mem_rvalid = 1'b0;
            bif.mem_rdata  = '0;
            #1;
            check({v.name, ".T3.w_en"}, {63'd0, w_en_o}, {63'd0, v.exp_wen});
            check({v.name, ".T3.w_addr"}, {59'd0, w_addr_o}, v.exp_wen ? {59'd0, v.rd} : 64'd0);
            check({v.name, ".T3.w_data"}, w_data_o, v.exp_res);
            check({v.name, ".T3.hold"}, {63'd0, hold_pipeline_o}, 64'd0);
            step();
            check({v.name, ".T4.w_en"}, {63'd0, w_en_o}, 64'd0);
            check({v.name, ".T4.w_data"}, w_data_o, 64'd0);
            check({v.name, ".T4.ready"}, {63'd0, req_ready}, 64'd1);
         end
      end
   endtask

   vec_t vecs[19];

   initial begin
      vec_t v;
      logic [63:0] a0;
      logic [63:0] d0;

      vecs[0]  = '{"ld",      1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'h0, 5'd5,  64'h1122_3344_5566_7788, K_LOAD,  64'h8000_0008, 64'h0, 8'h00, 1'b1, 64'h1122_3344_5566_7788};
      vecs[1]  = '{"lb",      1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'h0, 5'd7,  64'h0000_0000_8000_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[2]  = '{"lbu",     1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'h0, 5'd7,  64'h0000_0000_8000_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'h0000_0000_0000_0080};
      vecs[3]  = '{"lh",      1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'h0, 5'd10, 64'h8001_0000_0000_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
      vecs[4]  = '{"lhu",     1'b1, 1'b0, 3'b101, 64'h8000_0002, 64'h0, 5'd11, 64'h0000_0000_F00D_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'h0000_0000_0000_F00D};
      vecs[5]  = '{"lw",      1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'h0, 5'd12, 64'h8765_4321_0000_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'hFFFF_FFFF_8765_4321};
      vecs[6]  = '{"lwu",     1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'h0, 5'd12, 64'h8765_4321_0000_0000, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b1, 64'h0000_0000_8765_4321};
      vecs[7]  = '{"lw_x0",   1'b1, 1'b0, 3'b010, 64'h8000_0000, 64'h0, 5'd0,  64'h0000_0000_0000_0007, K_LOAD,  64'h8000_0000, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[8]  = '{"sh",      1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h1234_0000_0000_ABCD, 5'd0, 64'h0, K_STORE, 64'h8000_0000, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 1'b0, 64'h0};
      vecs[9]  = '{"sb",      1'b0, 1'b1, 3'b000, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FF5A, 5'd0, 64'h0, K_STORE, 64'h8000_0000, 64'h5A5A_5A5A_5A5A_5A5A, 8'h20, 1'b0, 64'h0};
      vecs[10] = '{"sw",      1'b0, 1'b1, 3'b010, 64'h8000_000C, 64'hFFFF_FFFF_DEAD_BEEF, 5'd0, 64'h0, K_STORE, 64'h8000_0008, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 1'b0, 64'h0};
      vecs[11] = '{"sd",      1'b0, 1'b1, 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h0, K_STORE, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'h0};
      vecs[12] = '{"lw_mis",  1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0, 5'd3,  64'h0, K_MISAL, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[13] = '{"sd_mis",  1'b0, 1'b1, 3'b011, 64'h8000_0004, 64'h0, 5'd0,  64'h0, K_MISAL, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[14] = '{"lh_mis",  1'b1, 1'b0, 3'b001, 64'h8000_0001, 64'h0, 5'd4,  64'h0, K_MISAL, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[15] = '{"st_f3",   1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'h0, 5'd0,  64'h0, K_IGN,   64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[16] = '{"ld_f3",   1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'h0, 5'd6,  64'h0, K_IGN,   64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[17] = '{"ld_st",   1'b1, 1'b1, 3'b011, 64'h8000_0000, 64'h0, 5'd6,  64'h0, K_IGN,   64'h0, 64'h0, 8'h00, 1'b0, 64'h0};
      vecs[18] = '{"no_op",   1'b0, 1'b0, 3'b011, 64'h8000_0000, 64'h0, 5'd6,  64'h0, K_IGN,   64'h0, 64'h0, 8'h00, 1'b0, 64'h0};

      bif.mem_ready  = 1'b0;
      bif.mem_rvalid = 1'b0;
      bif.mem_rdata  = '0;

      // Reset state.
      #12;
      check("rst.ready", {63'd0, req_ready}, 64'd1);
      check("rst.mem_valid", {63'd0, bif.mem_valid}, 64'd0);
      check("rst.hold", {63'd0, hold_pipeline_o}, 64'd0);
      check("rst.w_en", {63'd0, w_en_o}, 64'd0);
      check("rst.misalign", {63'd0, misalign_o}, 64'd0);
      check("rst.w_data", w_data_o, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table, back to back.
      for (int i = 0; i < 19; i++) begin
         apply_vec(vecs[i]);
      end

      // LD with one bus wait state after the handshake; rvalid during REQ must be ignored.
      v = vecs[0];
      drive_req(v);
      #1;
      check("ldw.T.hold", {63'd0, hold_pipeline_o}, 64'd1);
      step();
      clear_req();
      bif.mem_ready  = 1'b1;
      bif.mem_rvalid = 1'b1;
      bif.mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
      #1;
      check("ldw.T1.hold", {63'd0, hold_pipeline_o}, 64'd1);
      check("ldw.T1.mem_valid", {63'd0, bif.mem_valid}, 64'd1);
      step();
      bif.mem_ready  = 1'b0;
      bif.mem_rvalid = 1'b0;
      bif.mem_rdata  = '0;
      #1;
      check("ldw.T2.hold", {63'd0, hold_pipeline_o}, 64'd1);
      check("ldw.T2.w_en", {63'd0, w_en_o}, 64'd0);
      step();
      bif.mem_rvalid = 1'b1;
      bif.mem_rdata  = 64'h1122_3344_5566_7788;
      #1;
      check("ldw.T3.hold", {63'd0, hold_pipeline_o}, 64'd1);
      check("ldw.T3.w_en", {63'd0, w_en_o}, 64'd0);
      step();
      bif.mem_rvalid = 1'b0;
      bif.mem_rdata  = '0;
      #1;
      check("ldw.T4.w_en", {63'd0, w_en_o}, 64'd1);
      check("ldw.T4.w_addr", {59'd0, w_addr_o}, 64'd5);
      check("ldw.T4.w_data", w_data_o, 64'h1122_3344_5566_7788);
      check("ldw.T4.hold", {63'd0, hold_pipeline_o}, 64'd0);
      step();
      check("ldw.T5.w_en", {63'd0, w_en_o}, 64'd0);

      // SD with five cycles of mem_ready low: bus outputs frozen for six cycles.
      v = vecs[11];
      drive_req(v);
      #1;
      check("sds.T.hold", {63'd0, hold_pipeline_o}, 64'd1);
      step();
      clear_req();
      a0 = bif.mem_addr;
      d0 = bif.mem_wdata;
      for (int c = 1; c <= 6; c++) begin
         bif.mem_ready = (c == 6);
         #1;
         check($sformatf("sds.c%0d.mem_valid", c), {63'd0, bif.mem_valid}, 64'd1);
         check($sformatf("sds.c%0d.mem_addr", c), bif.mem_addr, 64'h8000_0010);
         check($sformatf("sds.c%0d.mem_wdata", c), bif.mem_wdata, 64'h0123_4567_89AB_CDEF);
         check($sformatf("sds.c%0d.addr_stable", c), bif.mem_addr, a0);
         check($sformatf("sds.c%0d.wdata_stable", c), bif.mem_wdata, d0);
         check($sformatf("sds.c%0d.hold", c), {63'd0, hold_pipeline_o}, 64'd1);
         step();
      end
      bif.mem_ready = 1'b0;
      #1;
      check("sds.end.mem_valid", {63'd0, bif.mem_valid}, 64'd0);
      check("sds.end.hold", {63'd0, hold_pipeline_o}, 64'd0);
      check("sds.end.ready", {63'd0, req_ready}, 64'd1);

      // LD abandoned by reset in WAIT; a late rvalid must not write back.
      v = vecs[0];
      drive_req(v);
      step();
      clear_req();
      bif.mem_ready = 1'b1;
      step();
      bif.mem_ready = 1'b0;
      #1;
      check("rsw.wait.hold", {63'd0, hold_pipeline_o}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rsw.mem_valid", {63'd0, bif.mem_valid}, 64'd0);
      check("rsw.hold", {63'd0, hold_pipeline_o}, 64'd0);
      check("rsw.w_en", {63'd0, w_en_o}, 64'd0);
      check("rsw.ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bif.mem_rvalid = 1'b1;
      bif.mem_rdata  = 64'h1122_3344_5566_7788;
      step();
      bif.mem_rvalid = 1'b0;
      bif.mem_rdata  = '0;
      #1;
      check("rsw.late.w_en", {63'd0, w_en_o}, 64'd0);
      check("rsw.late.hold", {63'd0, hold_pipeline_o}, 64'd0);
      step();
      check("rsw.late2.w_en", {63'd0, w_en_o}, 64'd0);

      // Normal operation resumes after the reset.
      apply_vec(vecs[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
